// File: rtl/mic1_mem_arbiter_if.sv
// mic1_mem_arbiter_if -- bundle of the two requester ports (fetch, data),
// the shared byte-wide external memory port and the error flag.
//   slave  : arbiter side (takes requests, drives the external port)
//   master : requester + memory side (testbench / surrounding core)
interface mic1_mem_arbiter_if;
  // fetch port (PC -> MBR)
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_ack;
  logic [7:0]  f_data;
  // data port (MAR/MDR)
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        err;
  // external byte memory
  logic        ext_valid;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_ready;
  logic [7:0]  ext_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, ext_ready, ext_rdata,
    output f_ack, f_data, d_ack, d_rdata, err, ext_valid, ext_we, ext_addr, ext_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, ext_ready, ext_rdata,
    input  f_ack, f_data, d_ack, d_rdata, err, ext_valid, ext_we, ext_addr, ext_wdata
  );
endinterface

// File: rtl/mic1_mem_arbiter.sv
// mic1_mem_arbiter -- shares one byte-wide external memory between the MIC-1
// instruction fetch port (byte reads) and the data port (16-bit little-endian
// words, done as two byte accesses). One access in flight; round-robin on
// contention; each byte access aborts after TIMEOUT cycles without ext_ready.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mic1_mem_arbiter_if.slave (fetch, data, err and external ports)
module mic1_mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input logic                 clk,
  input logic                 rst,
  mic1_mem_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, F_ACC, D_LO, D_HI, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        last_d;     // 1: previous grant went to data port
  logic        gnt_d;      // current transaction belongs to data port
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  lo_q, hi_q;
  logic        err_q;
  logic [7:0]  wcnt;

  logic acc, take_d, tmo;

  assign acc = (state == F_ACC) || (state == D_LO) || (state == D_HI);
  // data wins when alone, or on contention if fetch was served last
  assign take_d = bus.d_req && (!bus.f_req || !last_d);
  assign tmo = acc && !bus.ext_ready && (wcnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.f_req || bus.d_req) state_nxt = take_d ? D_LO : F_ACC;
      F_ACC: if (bus.ext_ready || tmo) state_nxt = RESP;
      D_LO:  if (bus.ext_ready) state_nxt = D_HI;
             else if (tmo) state_nxt = RESP;   // abort skips the high byte
      D_HI:  if (bus.ext_ready || tmo) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      gnt_d   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
      wcnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.f_req || bus.d_req) begin
          // latch the whole request; requester may change inputs afterwards
          gnt_d   <= take_d;
          addr_q  <= take_d ? bus.d_addr : bus.f_addr;
          we_q    <= take_d && bus.d_we;
          wdata_q <= take_d ? bus.d_wdata : 16'h0000;
          lo_q    <= '0;   // bytes not captured before an abort read as 0
          hi_q    <= '0;
          err_q   <= 1'b0;
          wcnt    <= '0;
        end
        F_ACC, D_LO, D_HI: begin
          if (bus.ext_ready) begin
            wcnt <= '0;
            if (!we_q) begin
              if (state == D_HI) hi_q <= bus.ext_rdata;
              else               lo_q <= bus.ext_rdata;
            end
          end else if (tmo) begin
            err_q <= 1'b1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        RESP: last_d <= gnt_d;
        default: ;
      endcase
    end
  end

  assign bus.ext_valid = acc;
  assign bus.ext_we    = acc && we_q;
  assign bus.ext_addr  = (state == D_HI) ? addr_q + 16'd1 : addr_q;
  assign bus.ext_wdata = (state == D_HI) ? wdata_q[15:8] : wdata_q[7:0];

  assign bus.f_ack   = (state == RESP) && !gnt_d;
  assign bus.d_ack   = (state == RESP) && gnt_d;
  assign bus.err     = (state == RESP) && err_q;
  assign bus.f_data  = lo_q;
  assign bus.d_rdata = {hi_q, lo_q};

endmodule

// File: tb/tb_mic1_mem_arbiter.sv
// tb_mic1_mem_arbiter -- directed test of mic1_mem_arbiter. Two instances
// (TIMEOUT=15 and TIMEOUT=4) see identical stimulus. The memory returns
// addr[7:0]^addr[15:8]^0x83 for every byte, so 0x1234 reads 0xA5.
module tb_mic1_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mic1_mem_arbiter_if bus();
  mic1_mem_arbiter_if bus4();

  mic1_mem_arbiter #(.TIMEOUT(15)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  mic1_mem_arbiter #(.TIMEOUT(4))  u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  assign bus.ext_ready  = rdy;
  assign bus.ext_rdata  = bus.ext_addr[7:0] ^ bus.ext_addr[15:8] ^ 8'h83;
  assign bus4.ext_ready = rdy;
  assign bus4.ext_rdata = bus4.ext_addr[7:0] ^ bus4.ext_addr[15:8] ^ 8'h83;
  assign bus4.f_req   = bus.f_req;
  assign bus4.f_addr  = bus.f_addr;
  assign bus4.d_req   = bus.d_req;
  assign bus4.d_we    = bus.d_we;
  assign bus4.d_addr  = bus.d_addr;
  assign bus4.d_wdata = bus.d_wdata;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_valid"}, 32'(bus.ext_valid), 32'd0);
    chk({tag, "_acks"},  32'({bus.f_ack, bus.d_ack, bus.err, bus.ext_we}), 32'd0);
    chk({tag, "_fdata"}, 32'(bus.f_data), 32'd0);
    chk({tag, "_drdata"}, 32'(bus.d_rdata), 32'd0);
    chk({tag, "_eaddr"}, 32'(bus.ext_addr), 32'd0);
    chk({tag, "_ewdata"}, 32'(bus.ext_wdata), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) cyc();
    chk_rst("reset");
    rst = 1'b0;

    // fetch 0x1234, ready=1: addr in cycle 1, ack in cycle 2
    cyc();
    bus.f_req = 1'b1; bus.f_addr = 16'h1234;
    cyc();
    chk("f1_valid", 32'(bus.ext_valid), 32'd1);
    chk("f1_addr",  32'(bus.ext_addr), 32'h1234);
    chk("f1_we",    32'(bus.ext_we), 32'd0);
    chk("f1_ack_early", 32'(bus.f_ack), 32'd0);
    cyc();
    chk("f1_ack",  32'({bus.f_ack, bus.d_ack}), 32'b10);
    chk("f1_data", 32'(bus.f_data), 32'hA5);
    chk("f1_err",  32'(bus.err), 32'd0);
    bus.f_req = 1'b0;
    cyc();
    chk("f1_idle", 32'({bus.ext_valid, bus.f_ack}), 32'd0);

    // word write at 0xFFFF wraps high byte to 0x0000; inputs change after grant
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'hFFFF; bus.d_wdata = 16'hBEEF;
    cyc();
    chk("w_lo_addr",  32'(bus.ext_addr), 32'hFFFF);
    chk("w_lo_data",  32'(bus.ext_wdata), 32'hEF);
    chk("w_lo_we",    32'(bus.ext_we), 32'd1);
    bus.d_we = 1'b0; bus.d_addr = 16'h0000; bus.d_wdata = 16'h1111;
    cyc();
    chk("w_hi_addr",  32'(bus.ext_addr), 32'h0000);
    chk("w_hi_data",  32'(bus.ext_wdata), 32'hBE);
    chk("w_hi_we",    32'(bus.ext_we), 32'd1);
    chk("w_ack_early", 32'(bus.d_ack), 32'd0);
    cyc();
    chk("w_ack", 32'({bus.f_ack, bus.d_ack, bus.err}), 32'b010);
    bus.d_req = 1'b0;
    cyc();

    // contention from reset: data first, then fetch, then data again
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 16'h1234;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h2000;
    cyc();
    chk("c_gnt_d", 32'(bus.ext_addr), 32'h2000);
    cyc();
    chk("c_hi_addr", 32'(bus.ext_addr), 32'h2001);
    cyc();
    chk("c_dack",  32'({bus.f_ack, bus.d_ack}), 32'b01);
    chk("c_rdata", 32'(bus.d_rdata), 32'hA2A3);
    bus.d_req = 1'b0;
    cyc();
    chk("c_resample", 32'({bus.ext_valid, bus.f_ack, bus.d_ack}), 32'd0);
    cyc();
    chk("c_f_addr", 32'(bus.ext_addr), 32'h1234);
    cyc();
    chk("c_fack",  32'({bus.f_ack, bus.d_ack}), 32'b10);
    chk("c_fdata", 32'(bus.f_data), 32'hA5);
    bus.f_req = 1'b0;
    cyc();
    bus.f_req = 1'b1; bus.d_req = 1'b1; bus.d_addr = 16'h0010;
    cyc();
    chk("c2_gnt_d", 32'({bus.ext_valid, bus.ext_addr}), {15'd0, 1'b1, 16'h0010});
    repeat (2) cyc();
    chk("c2_dack",  32'({bus.f_ack, bus.d_ack}), 32'b01);
    chk("c2_rdata", 32'(bus.d_rdata), 32'h9293);
    bus.d_req = 1'b0;
    repeat (3) cyc();
    chk("c2_fack", 32'({bus.f_ack, bus.d_ack}), 32'b10);
    bus.f_req = 1'b0;
    cyc();

    // slow read: ready low 3 cycles per byte, ack in cycle 9 (also on TIMEOUT=4)
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h2000; rdy = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (c == 2) chk("s_lo_addr", 32'({bus.ext_valid, bus.ext_addr}), {15'd0, 1'b1, 16'h2000});
      if (c == 6) chk("s_hi_addr", 32'({bus.ext_valid, bus.ext_addr}), {15'd0, 1'b1, 16'h2001});
      if (c == 8) chk("s_ack_early", 32'(bus.d_ack), 32'd0);
      if (c == 9) begin
        chk("s_ack",   32'({bus.d_ack, bus.err}), 32'b10);
        chk("s_rdata", 32'(bus.d_rdata), 32'hA2A3);
        chk("s4_ack",  32'({bus4.d_ack, bus4.err}), 32'b10);
        chk("s4_rdata", 32'(bus4.d_rdata), 32'hA2A3);
        bus.d_req = 1'b0;
      end
      rdy = (c == 4) || (c == 8) || (c == 9);
    end
    cyc();

    // ready stuck low on a fetch: TIMEOUT=4 aborts in cycle 5, TIMEOUT=15 in cycle 16
    bus.f_req = 1'b1; bus.f_addr = 16'h1234; rdy = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      if (c == 4) chk("t4_ack_early", 32'(bus4.f_ack), 32'd0);
      if (c == 5) begin
        chk("t4_ack",   32'({bus4.f_ack, bus4.err}), 32'b11);
        chk("t4_fdata", 32'(bus4.f_data), 32'h00);
        bus.f_req = 1'b0;
      end
      if (c == 6)  chk("t4_idle", 32'({bus4.ext_valid, bus4.f_ack, bus4.err}), 32'd0);
      if (c == 15) chk("t15_wait", 32'({bus.ext_valid, bus.f_ack}), 32'b10);
      if (c == 16) begin
        chk("t15_ack",   32'({bus.f_ack, bus.err}), 32'b11);
        chk("t15_fdata", 32'(bus.f_data), 32'h00);
        rdy = 1'b1;
      end
    end
    cyc();
    bus.f_req = 1'b1; bus.f_addr = 16'h00FF;
    repeat (2) cyc();
    chk("t_next",   32'({bus.f_ack, bus.err, bus.f_data}), {22'd0, 2'b10, 8'h7C});
    chk("t4_next",  32'({bus4.f_ack, bus4.err, bus4.f_data}), {22'd0, 2'b10, 8'h7C});
    bus.f_req = 1'b0;
    cyc();

    // reset during D_HI: no ack, everything back to reset values
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h3000; bus.d_wdata = 16'h1234;
    repeat (2) cyc();
    chk("r_dhi", 32'({bus.ext_valid, bus.ext_addr}), {15'd0, 1'b1, 16'h3001});
    rst = 1'b1;
    cyc();
    chk_rst("midrst");
    rst = 1'b0; bus.d_req = 1'b0;
    cyc();
    chk("r_noack", 32'({bus.d_ack, bus.ext_valid}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
